spi_flash_responder: RTL and testbench

- Synthesizable SPI mode-0 slave that answers the SoC SPI master with serial-flash READ (0x03) semantics. Serves bytes from an on-chip memory port.
- Fills the flash-responder end of the spi_clk/spi_cs/spi_mosi/spi_miso link, for FPGA bring-up and boot ROM emulation without an external flash part.
- All SPI pins are oversampled in the system clock domain.

---
 rtl/spi_flash_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 slave answering serial-flash READ (0x03)
// from an on-chip memory port. All SPI pins are oversampled in clk_i.
// Optional build macro SPI_FAST_READ_EN adds FAST READ (0x0B) with an
// 8-clock dummy phase. When it is undefined, 0x0B is dropped like any
// other unsupported command.
`timescale 1ns/1ps
module spi_flash_responder #(
  parameter int ADDR_W      = 24,
  parameter int MEM_AW      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              spi_clk_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              mem_rd_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i
);

  localparam int CNT_W = $clog2(ADDR_W) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_DROP
`ifdef SPI_FAST_READ_EN
    , S_DUMMY
`endif
  } state_e;

  state_e                   state_q;
  logic [SYNC_STAGES-1:0]   sck_sync_q;
  logic [SYNC_STAGES-1:0]   cs_sync_q;
  logic [SYNC_STAGES-1:0]   mosi_sync_q;
  logic                     sck_prev_q;
  logic                     armed_q;      // cs seen high since reset/last txn
  logic [CNT_W-1:0]         bit_cnt_q;    // command / address bit counter
  logic [2:0]               rcnt_q;       // rises within current data byte
  logic [2:0]               fcnt_q;       // falls within current data byte
  logic [6:0]               cmd_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [7:0]               tx_q;
  logic [7:0]               nxt_q;
  logic                     rd_tx_q;      // outstanding read targets tx_q
  logic                     rdv_q;        // mem_rdata_i valid this clk
  logic                     rdv_tx_q;
`ifdef SPI_FAST_READ_EN
  logic                     fast_q;
  logic [2:0]               dummy_cnt_q;
`endif

  logic              sck_s, cs_s, mosi_s, rise, fall;
  logic [7:0]        cmd_d;
  logic [ADDR_W-1:0] addr_shift_d;
  logic [ADDR_W-1:0] addr_inc_d;

  assign sck_s        = sck_sync_q[SYNC_STAGES-1];
  assign cs_s         = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
  assign rise         = sck_s & ~sck_prev_q;
  assign fall         = ~sck_s & sck_prev_q;
  assign cmd_d        = {cmd_q, mosi_s};
  assign addr_shift_d = {addr_q[ADDR_W-2:0], mosi_s};
  assign addr_inc_d   = addr_q + ADDR_W'(1);

  // Synchronize SPI pins into clk_i and keep last synced sck for edge detect
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev_q  <= sck_s;
    end
  end

  // Protocol FSM with registered SPI and memory-port outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      armed_q       <= 1'b0;
      bit_cnt_q     <= '0;
      rcnt_q        <= '0;
      fcnt_q        <= '0;
      cmd_q         <= '0;
      addr_q        <= '0;
      tx_q          <= '0;
      nxt_q         <= '0;
      rd_tx_q       <= 1'b0;
      rdv_q         <= 1'b0;
      rdv_tx_q      <= 1'b0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      mem_rd_o      <= 1'b0;
      mem_addr_o    <= '0;
`ifdef SPI_FAST_READ_EN
      fast_q        <= 1'b0;
      dummy_cnt_q   <= '0;
`endif
    end else begin
      mem_rd_o <= 1'b0;
      // An in-flight read always completes; its data is only used in DATA.
      rdv_q    <= mem_rd_o;
      rdv_tx_q <= rd_tx_q;
      if (cs_s) begin
        // Deselect wins over any same-cycle sck edge.
        state_q       <= S_IDLE;
        armed_q       <= 1'b1;
        bit_cnt_q     <= '0;
        rcnt_q        <= '0;
        fcnt_q        <= '0;
        cmd_q         <= '0;
        addr_q        <= '0;
        tx_q          <= '0;
        nxt_q         <= '0;
        spi_miso_o    <= 1'b0;
        spi_miso_oe_o <= 1'b0;
`ifdef SPI_FAST_READ_EN
        dummy_cnt_q   <= '0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            // A cs already low when reset released is ignored until re-armed.
            if (armed_q) begin
              state_q   <= S_CMD;
              armed_q   <= 1'b0;
              bit_cnt_q <= '0;
            end
          end
          S_CMD: begin
            if (rise) begin
              cmd_q     <= cmd_d[6:0];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == CMD_LAST) begin
                bit_cnt_q <= '0;
                if (cmd_d == 8'h03) begin
                  state_q <= S_ADDR;
`ifdef SPI_FAST_READ_EN
                  fast_q  <= 1'b0;
                end else if (cmd_d == 8'h0B) begin
                  state_q <= S_ADDR;
                  fast_q  <= 1'b1;
`endif
                end else begin
                  state_q <= S_DROP;
                end
              end
            end
          end
          S_ADDR: begin
            if (rise) begin
              addr_q    <= addr_shift_d;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == ADDR_LAST) begin
                bit_cnt_q <= '0;
`ifdef SPI_FAST_READ_EN
                if (fast_q) begin
                  state_q     <= S_DUMMY;
                  dummy_cnt_q <= '0;
                end else
`endif
                begin
                  mem_rd_o      <= 1'b1;
                  mem_addr_o    <= addr_shift_d[MEM_AW-1:0];
                  rd_tx_q       <= 1'b1;
                  state_q       <= S_DATA;
                  spi_miso_oe_o <= 1'b1;
                  rcnt_q        <= '0;
                  fcnt_q        <= '0;
                end
              end
            end
          end
`ifdef SPI_FAST_READ_EN
          S_DUMMY: begin
            if (rise) begin
              dummy_cnt_q <= dummy_cnt_q + 3'd1;
              if (dummy_cnt_q == 3'd7) begin
                mem_rd_o      <= 1'b1;
                mem_addr_o    <= addr_q[MEM_AW-1:0];
                rd_tx_q       <= 1'b1;
                state_q       <= S_DATA;
                spi_miso_oe_o <= 1'b1;
                rcnt_q        <= '0;
                fcnt_q        <= '0;
              end
            end
          end
`endif
          S_DATA: begin
            if (rdv_q) begin
              if (rdv_tx_q) tx_q  <= mem_rdata_i;
              else          nxt_q <= mem_rdata_i;
            end
            if (fall) begin
              spi_miso_o <= tx_q[7];
              fcnt_q     <= fcnt_q + 3'd1;
              // Last bit of the byte leaves; prefetched byte takes its place.
              if (fcnt_q == 3'd7) tx_q <= nxt_q;
              else                tx_q <= {tx_q[6:0], 1'b0};
            end
            if (rise) begin
              rcnt_q <= rcnt_q + 3'd1;
              // Prefetch on the second-to-last bit so the next byte is ready.
              if (rcnt_q == 3'd6) begin
                addr_q     <= addr_inc_d;
                mem_rd_o   <= 1'b1;
                mem_addr_o <= addr_inc_d[MEM_AW-1:0];
                rd_tx_q    <= 1'b0;
              end
            end
          end
          S_DROP: begin
            spi_miso_oe_o <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: an SPI master at clk/8, a
// one-cycle-latency memory model, and expected address/byte queues.
`timescale 1ns/1ps
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, oe, mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_addr_q [$];
  logic [15:0] obs_addr_q [$];
  logic [7:0]  exp_byte_q [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          oe_cnt = 0;

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_W(24), .MEM_AW(16), .SYNC_STAGES(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .spi_clk_i    (sck),
    .spi_cs_i     (cs),
    .spi_mosi_i   (mosi),
    .spi_miso_o   (miso),
    .spi_miso_oe_o(oe),
    .mem_rd_o     (mem_rd),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata)
  );

  // Memory: data valid one clk after the read strobe
  always @(posedge clk) if (mem_rd === 1'b1) mem_rdata <= mem[mem_addr];

  // Observe read strobes and output-enable cycles away from the active edge
  always @(negedge clk) begin
    if (mem_rd === 1'b1) obs_addr_q.push_back(mem_addr);
    if (oe === 1'b1) oe_cnt = oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    tick(4);
    m = miso;
    sck = 1'b1;
    tick(4);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  // One transaction: cmd, 24-bit address, ndummy bits, nbytes data bytes
  task automatic run_txn(input string name, input logic [7:0] cmd, input logic [23:0] addr,
                         input int ndummy, input int nbytes, input bit expect_data);
    logic [7:0]  rx;
    logic [23:0] a;
    logic        m;
    int          oe0;
    oe0 = oe_cnt;
    obs_addr_q.delete();
    exp_addr_q.delete();
    if (expect_data) begin
      // One read per byte plus the prefetch issued during the final byte.
      for (int i = 0; i <= nbytes; i++) begin
        a = addr + 24'(i);
        exp_addr_q.push_back(a[15:0]);
        if (i < nbytes) exp_byte_q.push_back(mem[a[15:0]]);
      end
    end
    cs = 1'b0;
    tick(4);
    spi_byte(cmd, rx);
    spi_byte(addr[23:16], rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
    for (int d = 0; d < ndummy; d++) spi_bit(1'b1, m);
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(8'($urandom_range(0, 255)), rx);
      if (expect_data) check({name, "_byte"}, {24'h0, rx}, {24'h0, exp_byte_q.pop_front()});
    end
    tick(4);
    cs = 1'b1;
    tick(10);
    check({name, "_rd_count"}, obs_addr_q.size(), expect_data ? nbytes + 1 : 0);
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0)
      check({name, "_addr"}, {16'h0, obs_addr_q.pop_front()}, {16'h0, exp_addr_q.pop_front()});
    check({name, "_oe_seen"}, {31'h0, oe_cnt != oe0}, {31'h0, expect_data});
  endtask

  initial begin
    logic [7:0] rx;
    logic       m;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'h0010] = 8'hA5;
    mem[16'h0100] = 8'h11;
    mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33;
    mem[16'h0103] = 8'h44;
    mem[16'hFFFF] = 8'hC3;
    mem[16'h0000] = 8'h7E;
    mem[16'h0020] = 8'h96;
    mem[16'h0004] = 8'h4B;
    mem[16'h0030] = 8'hFF;
    mem[16'h0008] = 8'h3C;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_oe", {31'h0, oe}, 32'h0);
    check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    rst_n = 1'b1;
    tick(10);

    run_txn("read_10", 8'h03, 24'h000010, 0, 1, 1'b1);
    run_txn("read_100x4", 8'h03, 24'h000100, 0, 4, 1'b1);
    run_txn("read_wrap", 8'h03, 24'hFFFFFF, 0, 2, 1'b1);
    run_txn("cmd_9f", 8'h9F, 24'hFFFFFF, 0, 1, 1'b0);
    run_txn("read_20", 8'h03, 24'h000020, 0, 1, 1'b1);

    // Abort after 12 address bits: no read may be issued
    obs_addr_q.delete();
    cs = 1'b0;
    tick(4);
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
    tick(4);
    cs = 1'b1;
    tick(10);
    check("abort_rd_count", obs_addr_q.size(), 0);
    run_txn("read_04", 8'h03, 24'h000004, 0, 1, 1'b1);

    // Reset in the middle of DATA
    obs_addr_q.delete();
    cs = 1'b0;
    tick(4);
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h30, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
    tick(4);
    check("pre_rst_oe", {31'h0, oe}, 32'h1);
    check("pre_rst_miso", {31'h0, miso}, 32'h1);
    check("pre_rst_rd_count", obs_addr_q.size(), 1);
    if (obs_addr_q.size() > 0) check("pre_rst_addr", {16'h0, obs_addr_q.pop_front()}, 32'h30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", {31'h0, miso}, 32'h0);
    check("mid_rst_oe", {31'h0, oe}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    // cs still low from before reset: a full READ must be ignored
    obs_addr_q.delete();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h00, rx);
    check("stale_cs_rd_count", obs_addr_q.size(), 0);
    check("stale_cs_oe", {31'h0, oe}, 32'h0);
    tick(4);
    cs = 1'b1;
    tick(10);
    run_txn("read_after_rst", 8'h03, 24'h000010, 0, 1, 1'b1);

`ifdef SPI_FAST_READ_EN
    run_txn("fast_read_08", 8'h0B, 24'h000008, 8, 1, 1'b1);
`else
    run_txn("fast_read_off", 8'h0B, 24'h000008, 8, 1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
